// File: rtl/fp16_pkg.sv
// Shared constants and the queued-entry layout for the FP16 adder result path.
package fp16_pkg;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_INF  = 3;
  localparam int FLAG_NAN  = 4;
  localparam int FLAG_W    = 5;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  // One buffered adder result: 16 + 5 + 1 = 22 bits.
  typedef struct packed {
    logic [15:0]       result;
    logic [FLAG_W-1:0] flags;
    logic              last;
  } fp16_entry_t;

  localparam int ENTRY_W = $bits(fp16_entry_t);

endpackage

// File: rtl/fp16_sync_fifo.sv
// Generic synchronous FIFO: registered pointers and occupancy, head read straight from storage.
module fp16_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fp16_result_buffer.sv
// Capture buffer behind the FP16 adder: queues results, flags overflow drops, tracks sticky exceptions.
module fp16_result_buffer
  import fp16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [15:0]             in_result,
  input  logic [4:0]              in_flags,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_result,
  output logic [4:0]              out_flags,
  output logic                    out_last,
  output logic [$clog2(DEPTH):0]  count,
  output logic [4:0]              sticky_flags,
  input  logic                    clear_sticky,
  output logic [CNT_W-1:0]        drop_count,
  output logic                    frame_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_ONE = 1;

  fp16_entry_t wr_e, rd_e;
  logic        full, push, pop, drop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & ~push;

  assign wr_e = '{result: in_result, flags: in_flags, last: in_last};

  fp16_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_e),
    .rd_data (rd_e),
    .count   (count)
  );

  assign out_result = rd_e.result;
  assign out_flags  = rd_e.flags;
  assign out_last   = rd_e.last;

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_flags <= '0;
      drop_count   <= '0;
      frame_done   <= 1'b0;
    end else begin
      // Flags pushed alongside a clear survive it.
      sticky_flags <= (clear_sticky ? 5'b0 : sticky_flags) | (push ? in_flags : 5'b0);
      if (drop && drop_count != '1) drop_count <= drop_count + DROP_ONE;
      frame_done <= pop & out_last;
    end
  end

endmodule

// File: tb/tb_fp16_result_buffer.sv
// Randomized and directed checks of fp16_result_buffer against a queue-based reference model.
module tb_fp16_result_buffer;
  import fp16_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_result = '0;
  logic [4:0]  in_flags = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic        out_last;
  logic [$clog2(DEPTH):0] count;
  logic [4:0]  sticky_flags;
  logic        clear_sticky = 1'b0;
  logic [CNT_W-1:0] drop_count;
  logic        frame_done;

  fp16_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_flags(in_flags), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_last(out_last), .count(count),
    .sticky_flags(sticky_flags), .clear_sticky(clear_sticky), .drop_count(drop_count),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  fp16_entry_t q[$];
  logic [4:0]  m_sticky = '0;
  int          m_drop = 0;
  bit          m_fd = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("out_result", 32'(out_result), 32'(q[0].result));
      chk("out_flags", 32'(out_flags), 32'(q[0].flags));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end
    chk("sticky", 32'(sticky_flags), 32'(m_sticky));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic iv, input logic [15:0] r, input logic [4:0] f,
                      input logic l, input logic rdy, input logic clr, input logic rst);
    bit p_pop, p_push, pl;
    in_valid = iv; in_result = r; in_flags = f; in_last = l;
    out_ready = rdy; clear_sticky = clr; reset = rst;
    if (rst) begin
      q.delete(); m_sticky = '0; m_drop = 0; m_fd = 1'b0;
    end else begin
      p_pop  = (q.size() > 0) && rdy;
      p_push = iv && ((q.size() < DEPTH) || p_pop);
      pl = 1'b0;
      if (p_pop) begin pl = q[0].last; void'(q.pop_front()); end
      if (p_push) q.push_back('{result: r, flags: f, last: l});
      if (iv && !p_push && m_drop < DROP_MAX) m_drop++;
      m_sticky = (clr ? 5'b0 : m_sticky) | (p_push ? f : 5'b0);
      m_fd = p_pop && pl;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 5'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clock); #1;
    step(1'b1, 16'h1234, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);

    // single push, one-cycle latency, then drains
    step(1'b1, 16'h3C00, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_result", 32'(out_result), 32'h3C00);
    idle(1'b1);
    chk("t1_count0", 32'(count), 32'd0);

    // overfill by two
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_drop", 32'(drop_count), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 32'(out_result), 32'(i));
      idle(1'b1);
    end

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0010 + 16'(i), 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00AA, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_drop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t3_last_new", 32'(out_result), 32'h00AA);
    idle(1'b1);

    // sticky flags and clear-with-push
    step(1'b1, FP16_QNAN, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, FP16_POS_INF, 5'b01001, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_sticky", 32'(sticky_flags), 32'b11001);
    step(1'b1, FP16_ZERO, 5'b00100, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_clr_push", 32'(sticky_flags), 32'b00100);
    idle(1'b1); idle(1'b1);

    // frame_done pulse
    step(1'b1, 16'h4000, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("t5_fd_on", 32'(frame_done), 32'd1);
    idle(1'b1);
    chk("t5_fd_off", 32'(frame_done), 32'd0);

    // reset with three queued
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_sticky", 32'(sticky_flags), 32'd0);
    chk("t6_drop", 32'(drop_count), 32'd0);

    // drop counter saturation
    for (int i = 0; i < DROP_MAX + 10; i++)
      step(1'b1, 16'(i), 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_count), 32'(DROP_MAX));
    step(1'b0, 16'h0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 127) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_result_buffer.md
# fp16_result_buffer

Downstream capture stage for `fp_adder_16_bit`. It accepts one adder result plus its five status flags per cycle, queues them in a small synchronous FIFO, and presents them to the consumer over a valid/ready interface. It also keeps sticky exception flags and a saturating drop counter, because the adder has no backpressure and a full buffer must lose data visibly rather than silently.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of `drop_count`.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: the adder output is valid this cycle.
- `in_result` in 16: FP16 result.
- `in_flags` in 5: {NaN, infinity, zero, underflow, overflow}, bit 4 down to bit 0.
- `in_last` in 1: copy of `final_operation`; marks the last result of a frame.
- `out_valid` out 1: head entry is available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_result` out 16: head result.
- `out_flags` out 5: head flags, same order as `in_flags`.
- `out_last` out 1: head entry's last marker.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `sticky_flags` out 5: OR of the flags of every accepted entry since the last clear.
- `clear_sticky` in 1: clears `sticky_flags`.
- `drop_count` out CNT_W: number of entries dropped while full; saturates.
- `frame_done` out 1: one-cycle pulse after an entry with `out_last`=1 is popped.

## Operation
- Push: `in_valid`=1 and (not full, or a pop happens in the same cycle). The entry is written at the write pointer.
- Pop: `out_valid`=1 and `out_ready`=1. The read pointer advances.
- Full with `in_valid`=1 and no pop: the entry is discarded. `drop_count` increments and stops at 2^CNT_W−1. `sticky_flags` are not updated from the dropped entry.
- Full with simultaneous push and pop: both happen, `count` stays at DEPTH, and nothing is dropped.
- Empty with simultaneous push and pop: no pop, because `out_valid`=0. The push is accepted.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty are derived from `count`.
- `sticky_flags` next value = (`clear_sticky` ? 0 : `sticky_flags`) | (push ? `in_flags` : 0). When a clear and a push happen in the same cycle, the pushed flags survive.
- `out_result`, `out_flags`, `out_last` are driven from the head storage entry. They are don't-care when `out_valid`=0; the bench must not check them then.
- `frame_done` is registered: it is 1 in the cycle after a pop of an entry with `out_last`=1.
- Data is not inspected. NaN and infinity payloads pass through bit-exact.

## Timing
- Reset values: `out_valid`=0, `count`=0, `sticky_flags`=0, `drop_count`=0, `frame_done`=0. Pointers are 0. Storage contents are not reset.
- Reset mid-operation discards all queued entries. Inputs presented during the reset cycle are ignored.
- Push-to-output latency is one cycle. An entry pushed at edge N gives `out_valid`=1 after edge N; there is no combinational fall-through.
- `out_valid` depends only on registered state. It never depends combinationally on `out_ready`.
- A push gives one entry per cycle, and the block sustains full throughput when `out_ready` is held at 1.
- `count`, `sticky_flags`, and `drop_count` reflect the events of edge N immediately after edge N.

## Structure
- Package `fp16_pkg`:
  - flag index constants `FLAG_OVF`=0, `FLAG_UF`=1, `FLAG_ZERO`=2, `FLAG_INF`=3, `FLAG_NAN`=4;
  - `FLAG_W`=5;
  - FP16 encodings `FP16_POS_INF`=16'h7C00, `FP16_QNAN`=16'h7E00, `FP16_ZERO`=16'h0000.
- Sub-module `fp16_sync_fifo`: generic width/depth storage with pointers and `count`, 22 bits wide (result + flags + last).
- The top level adds the drop logic, sticky flags, drop counter, and `frame_done`.

## Test plan
- Push 16'h3C00 with flags 5'b00000, `out_ready`=1. Expect `out_valid` one cycle later with `out_result`=16'h3C00, then `count` returns to 0.
- With `out_ready`=0, push 6 entries, 16'h0001 through 16'h0006. Expect `count`=4 and `drop_count`=2. Then drain and expect 0001..0004 in order.
- When full, drive push and pop in the same cycle. Expect `count` to stay at 4, `drop_count` unchanged, and the new entry to appear last.
- Push 16'h7E00 with 5'b10000, then 16'h7C00 with 5'b01001. Expect `sticky_flags`=5'b11001. Assert `clear_sticky` together with a push of 5'b00100 and expect 5'b00100.
- Push an entry with `in_last`=1 and pop it. Expect `frame_done`=1 for exactly one cycle after the pop.
- With 3 entries queued, assert `reset` for one cycle. Expect `out_valid`=0, `count`=0, `sticky_flags`=0, `drop_count`=0 on the next cycle.
